// File: rtl/timers_pkg.sv
// Shared types for the trigger timestamping path: event record and drain FSM states.
package timers_pkg;

    // Widest channel index an event can carry; NUMCHANNELS must not exceed MAX_CHANNELS.
    localparam int MAX_CHANNELS = 64;
    localparam int EVT_CH_W     = $clog2(MAX_CHANNELS);

    typedef struct packed {
        logic [EVT_CH_W-1:0] channel;
        logic [31:0]         timestamp;
    } event_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event FIFO with synchronous flush and occupancy count.
// A pop frees its slot for a push in the same cycle, even when full.
module event_fifo
    import timers_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter type data_t = event_t,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  data_t         push_data,
    output logic          push_ready,
    input  logic          pop_ready,
    output logic          pop_valid,
    output data_t         pop_data,
    output logic [CW-1:0] count
);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          do_push;

    assign pop_valid  = (count != '0);
    assign pop        = pop_valid && pop_ready;
    assign push_ready = (count != CW'(DEPTH)) || pop;
    assign do_push    = push && push_ready;
    // Head is forced to zero when empty so stale storage never shows on the outputs.
    assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(pop);
        end
    end

    // Storage write; contents need no reset because the head is gated by pop_valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trigger_timestamper.sv
// Trigger timestamper: detects rising edges on unmasked channels, snapshots the
// timestamp, and serialises hit channels lowest-index-first into an event FIFO.
//
//   state | meaning
//   IDLE  | waiting for any unmasked rising edge to snapshot
//   DRAIN | writing one pending channel per cycle into the FIFO; new edges are dropped
module trigger_timestamper
    import timers_pkg::*;
#(
    parameter int  NUMCHANNELS = 64,
    parameter int  FIFO_DEPTH  = 8,
    parameter int  DROP_W      = 16,
    localparam int CH_W        = $clog2(NUMCHANNELS),
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUMCHANNELS-1:0] trigger_in,
    input  logic [NUMCHANNELS-1:0] channel_mask,
    input  logic [31:0]            timestamp_32b,
    input  logic                   sync_timestamp,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [CH_W-1:0]        event_channel,
    output logic [31:0]            event_timestamp,
    output logic [CNT_W-1:0]       fifo_count,
    output logic [DROP_W-1:0]      drop_count
);

    fsm_state_t             state;
    logic [NUMCHANNELS-1:0] trig_q;
    logic [NUMCHANNELS-1:0] rise;
    logic [NUMCHANNELS-1:0] pending;
    logic [NUMCHANNELS-1:0] pending_clr;
    logic [31:0]            ts_snap;
    logic [CH_W-1:0]        enc_idx;
    logic                   push;
    logic                   push_ready;
    logic                   advance;
    event_t                 push_data;
    event_t                 head;

    assign rise        = trigger_in & ~trig_q & ~channel_mask;
    // Clearing the lowest set bit matches the encoder's choice below.
    assign pending_clr = pending & (pending - NUMCHANNELS'(1));
    assign push        = (state == DRAIN) && !sync_timestamp;
    assign advance     = push && push_ready;

    // Lowest set bit of pending; the downward loop leaves the smallest index last.
    always_comb begin
        enc_idx = '0;
        for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) enc_idx = CH_W'(i);
        end
    end

    assign push_data.channel   = EVT_CH_W'(enc_idx);
    assign push_data.timestamp = ts_snap;

    // Trigger history for edge detection; updates even during sync so an edge is seen once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) trig_q <= '0;
        else          trig_q <= trigger_in;
    end

    // Snapshot / drain sequencing; sync overrides everything and discards same-cycle edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            ts_snap <= '0;
        end else if (sync_timestamp) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise != '0) begin
                        pending <= rise;
                        ts_snap <= timestamp_32b;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        pending <= pending_clr;
                        if (pending_clr == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of edge cycles lost while draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (sync_timestamp) begin
            drop_count <= '0;
        end else if ((state == DRAIN) && (rise != '0) && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

    event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .data_t (event_t)
    ) u_event_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (sync_timestamp),
        .push       (push),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_ready  (event_ready),
        .pop_valid  (event_valid),
        .pop_data   (head),
        .count      (fifo_count)
    );

    assign event_channel   = CH_W'(head.channel);
    assign event_timestamp = head.timestamp;

endmodule

// File: tb/tb_trigger_timestamper.sv
// Self-checking bench for trigger_timestamper: scoreboard of expected events plus
// directed checks on latency, back-pressure, drops, sync flush, saturation and reset.
module tb_trigger_timestamper;

    localparam int NCH   = 64;
    localparam int DEPTH = 8;
    localparam int DW    = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NCH-1:0]  trigger_in;
    logic [NCH-1:0]  channel_mask;
    logic [31:0]     timestamp_32b;
    logic            sync_timestamp;
    logic            event_valid;
    logic            event_ready;
    logic [5:0]      event_channel;
    logic [31:0]     event_timestamp;
    logic [3:0]      fifo_count;
    logic [DW-1:0]   drop_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          ch;
        logic [31:0] ts;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    trigger_timestamper #(
        .NUMCHANNELS (NCH),
        .FIFO_DEPTH  (DEPTH),
        .DROP_W      (DW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .trigger_in      (trigger_in),
        .channel_mask    (channel_mask),
        .timestamp_32b   (timestamp_32b),
        .sync_timestamp  (sync_timestamp),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .event_channel   (event_channel),
        .event_timestamp (event_timestamp),
        .fifo_count      (fifo_count),
        .drop_count      (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the events an accepted snapshot of these trigger bits should produce.
    task automatic expect_snapshot(input logic [63:0] bits, input logic [31:0] ts);
        for (int i = 0; i < NCH; i++) begin
            if (bits[i] && !channel_mask[i]) sb.push_back('{i, ts});
        end
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && event_valid && event_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pop", {63'd0, event_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("evt_channel", {58'd0, event_channel}, 64'(e.ch));
                check("evt_timestamp", {32'd0, event_timestamp}, {32'd0, e.ts});
            end
        end
    end

    initial begin
        logic [63:0] bits;
        reset_n        = 1'b0;
        trigger_in     = '0;
        channel_mask   = '0;
        timestamp_32b  = '0;
        sync_timestamp = 1'b0;
        event_ready    = 1'b1;
        #12;
        check("rst_valid", {63'd0, event_valid}, 64'd0);
        check("rst_channel", {58'd0, event_channel}, 64'd0);
        check("rst_timestamp", {32'd0, event_timestamp}, 64'd0);
        check("rst_count", {60'd0, fifo_count}, 64'd0);
        check("rst_drop", {60'd0, drop_count}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Single edge, no back-pressure.
        timestamp_32b = 32'h100;
        bits = 64'd1 << 5;
        expect_snapshot(bits, timestamp_32b);
        trigger_in = bits;
        tick();
        trigger_in = '0;
        check("t1_valid_early", {63'd0, event_valid}, 64'd0);
        tick();
        check("t1_valid_lat2", {63'd0, event_valid}, 64'd1);
        check("t1_channel", {58'd0, event_channel}, 64'd5);
        tick();
        tick();
        check("t1_count_zero", {60'd0, fifo_count}, 64'd0);

        // Multi-channel with one masked channel, max timestamp.
        timestamp_32b = 32'hFFFF_FFFF;
        channel_mask  = 64'd1 << 7;
        bits = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 40);
        expect_snapshot(bits, timestamp_32b);
        trigger_in = bits;
        tick();
        trigger_in = '0;
        tick();
        check("t2_first_ch", {58'd0, event_channel}, 64'd3);
        check("t2_first_ts", {32'd0, event_timestamp}, 64'hFFFF_FFFF);
        tick();
        check("t2_second_ch", {58'd0, event_channel}, 64'd40);
        tick();
        check("t2_count_zero", {60'd0, fifo_count}, 64'd0);
        channel_mask = '0;
        tick();

        // Back-pressure: fill, stall, drop three edges, then drain with pop+push at full.
        event_ready   = 1'b0;
        timestamp_32b = 32'h200;
        bits = 64'h3FF;
        expect_snapshot(bits, timestamp_32b);
        trigger_in = bits;
        tick();
        trigger_in = '0;
        repeat (10) tick();
        check("t3_full", {60'd0, fifo_count}, 64'd8);
        check("t3_valid", {63'd0, event_valid}, 64'd1);
        repeat (3) begin
            trigger_in[20] = 1'b1;
            tick();
            trigger_in[20] = 1'b0;
            tick();
        end
        check("t3_drop3", {60'd0, drop_count}, 64'd3);
        check("t3_still_full", {60'd0, fifo_count}, 64'd8);
        event_ready = 1'b1;
        tick();
        check("t6_pushpop_a", {60'd0, fifo_count}, 64'd8);
        tick();
        check("t6_pushpop_b", {60'd0, fifo_count}, 64'd8);
        tick();
        check("t6_drain_start", {60'd0, fifo_count}, 64'd7);
        repeat (10) tick();
        check("t3_empty", {60'd0, fifo_count}, 64'd0);
        check("t3_drop_kept", {60'd0, drop_count}, 64'd3);

        // Sync flush with 4 stored events, DRAIN active and a same-cycle ch 2 rise.
        event_ready   = 1'b0;
        timestamp_32b = 32'h300;
        trigger_in    = 64'h3F;
        tick();
        trigger_in = '0;
        repeat (4) tick();
        check("t4_count4", {60'd0, fifo_count}, 64'd4);
        sync_timestamp = 1'b1;
        trigger_in[2]  = 1'b1;
        tick();
        sync_timestamp = 1'b0;
        check("t4_valid0", {63'd0, event_valid}, 64'd0);
        check("t4_count0", {60'd0, fifo_count}, 64'd0);
        check("t4_drop0", {60'd0, drop_count}, 64'd0);
        tick();
        tick();
        trigger_in = '0;
        check("t4_no_ch2", {60'd0, fifo_count}, 64'd0);
        event_ready   = 1'b1;
        timestamp_32b = 32'h400;
        bits = 64'd1 << 11;
        expect_snapshot(bits, timestamp_32b);
        trigger_in = bits;
        tick();
        trigger_in = '0;
        tick();
        check("t4_idle_valid", {63'd0, event_valid}, 64'd1);
        check("t4_idle_ch", {58'd0, event_channel}, 64'd11);
        tick();
        tick();

        // Drop counter saturation, then reset mid-DRAIN.
        event_ready   = 1'b0;
        timestamp_32b = 32'h500;
        trigger_in    = 64'h3FF;
        tick();
        trigger_in = '0;
        repeat (10) tick();
        repeat (20) begin
            trigger_in[30] = 1'b1;
            tick();
            trigger_in[30] = 1'b0;
            tick();
        end
        check("t5_drop_sat", {60'd0, drop_count}, 64'd15);
        check("t5_full", {60'd0, fifo_count}, 64'd8);
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid", {63'd0, event_valid}, 64'd0);
        check("t5_rst_channel", {58'd0, event_channel}, 64'd0);
        check("t5_rst_ts", {32'd0, event_timestamp}, 64'd0);
        check("t5_rst_count", {60'd0, fifo_count}, 64'd0);
        check("t5_rst_drop", {60'd0, drop_count}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        event_ready   = 1'b1;
        timestamp_32b = 32'h600;
        bits = 64'd1 << 1;
        expect_snapshot(bits, timestamp_32b);
        trigger_in = bits;
        tick();
        trigger_in = '0;
        tick();
        check("t5_post_valid", {63'd0, event_valid}, 64'd1);
        check("t5_post_ch", {58'd0, event_channel}, 64'd1);
        check("t5_post_ts", {32'd0, event_timestamp}, 64'h600);
        repeat (3) tick();
        check("t5_post_empty", {60'd0, fifo_count}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
